nibble_add_sched: RTL

Time-shared scheduler for a single registered nibble adder (sum of two W-bit operands, W=4 by default). NREQ requesters each offer an operand pair over a valid/ready handshake. A round-robin arbiter picks one requester, the shared adder computes the sum, and the result is returned with the requester ID over a valid/ready response channel. It sits between the TinyTapeout pin-level wrapper and the adder datapath, so several pin-mapped sources can share one adder.

---
 rtl/nibble_add_pkg.sv | 18 +
 rtl/nibble_add_sched_rr_arbiter.sv | 36 +++
 rtl/nibble_add_sched.sv | 124 ++++++++++++
 3 files changed

// File: rtl/nibble_add_pkg.sv
// Shared types and defaults for the time-shared nibble adder scheduler.
// The id width helper keeps ID ports at least one bit wide.
package nibble_add_pkg;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_e;

  localparam int NREQ_DEF = 4;
  localparam int W_DEF    = 4;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nibble_add_sched_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or
// above ptr, wrapping from NREQ-1 back to 0.
module rr_arbiter
  import nibble_add_pkg::*;
#(
  parameter  int NREQ = NREQ_DEF,
  localparam int IDW  = id_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt_onehot,
  output logic [IDW-1:0]  gnt_idx,
  output logic            any_req
);

  int   idx;
  logic found;

  // Modulo keeps the scan correct for NREQ values that are not a power of two.
  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    any_req    = |req;
    found      = 1'b0;
    idx        = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && req[idx]) begin
        found           = 1'b1;
        gnt_onehot[idx] = 1'b1;
        gnt_idx         = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/nibble_add_sched.sv
// Schedules NREQ requesters onto one registered adder: arbitrate in IDLE,
// add in EXEC, hold the result in RESP until the consumer takes it.
module nibble_add_sched
  import nibble_add_pkg::*;
#(
  parameter  int NREQ = NREQ_DEF,
  parameter  int W    = W_DEF,
  localparam int IDW  = id_width(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req_valid,
  output logic [NREQ-1:0] req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [IDW-1:0]  rsp_id,
  output logic [W-1:0]    rsp_sum,
  output logic            rsp_carry,
  output logic            busy
);

  state_e         state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] g_q, g_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic [W-1:0]   rsp_sum_q, rsp_sum_d;
  logic           rsp_carry_q, rsp_carry_d;

  logic [NREQ-1:0] gnt_onehot;
  logic [IDW-1:0]  gnt_idx;
  logic            any_req;
  logic [W-1:0]    sel_a, sel_b;
  logic [W:0]      sum_full;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req        (req_valid),
    .ptr        (rr_ptr_q),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .any_req    (any_req)
  );

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_onehot[i]) begin
        sel_a = req_a[i*W +: W];
        sel_b = req_b[i*W +: W];
      end
    end
  end

  assign sum_full = {1'b0, a_q} + {1'b0, b_q};

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    g_d         = g_q;
    a_d         = a_q;
    b_d         = b_q;
    rsp_id_d    = rsp_id_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_carry_d = rsp_carry_q;
    req_ready   = '0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          req_ready = gnt_onehot;
          a_d       = sel_a;
          b_d       = sel_b;
          g_d       = gnt_idx;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        rsp_sum_d   = sum_full[W-1:0];
        rsp_carry_d = sum_full[W];
        rsp_id_d    = g_q;
        state_d     = RESP;
      end
      RESP: begin
        // The pointer only advances once the result is consumed.
        if (rsp_ready) begin
          rr_ptr_d = (g_q == IDW'(NREQ - 1)) ? '0 : g_q + IDW'(1);
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      g_q         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
      rsp_carry_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      g_q         <= g_d;
      a_q         <= a_d;
      b_q         <= b_d;
      rsp_id_q    <= rsp_id_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_carry_q <= rsp_carry_d;
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_carry = rsp_carry_q;

endmodule
